// File: rtl/usb_buffer_pkg.sv
// Shared types and sizing for the 64-byte USB endpoint data buffer.
package usb_buffer_pkg;

  localparam int BUFFER_DEPTH  = 64;
  localparam int BUFFER_DATA_W = 8;
  localparam int BUFFER_ADDR_W = 6;
  localparam int BUFFER_OCC_W  = 7;

  typedef logic [BUFFER_DATA_W-1:0] buffer_byte_t;

endpackage

// File: rtl/usb_buffer_mem.sv
// Register-array storage for the USB data buffer: one synchronous write port
// and one asynchronous read port.
module usb_buffer_mem #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset; validity is tracked by the occupancy
  // counter, so resetting 64 bytes would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/usb_data_buffer.sv
// Shared first-word-fall-through endpoint FIFO between the AHB slave and the
// USB packet engines. Define USB_BUFFER_ERR_EN to add sticky error flags.
module usb_data_buffer
  import usb_buffer_pkg::*;
#(
  parameter int DEPTH  = BUFFER_DEPTH,
  parameter int DATA_W = BUFFER_DATA_W,
  parameter int ADDR_W = BUFFER_ADDR_W
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    store_rx_packet_data,
  input  logic [DATA_W-1:0]       rx_packet_data,
  input  logic                    get_rx_data,
  output logic [DATA_W-1:0]       rx_data,
  input  logic                    store_tx_data,
  input  logic [DATA_W-1:0]       tx_data,
  input  logic                    get_tx_packet_data,
  output logic [DATA_W-1:0]       tx_packet_data,
  output logic [BUFFER_OCC_W-1:0] buffer_occupancy,
  output logic                    buffer_empty,
  output logic                    buffer_full
`ifdef USB_BUFFER_ERR_EN
  ,
  output logic                    buffer_overflow,
  output logic                    buffer_underflow,
  output logic                    buffer_collision
`endif
);

  logic [ADDR_W-1:0] wptr, rptr;
  logic [DATA_W-1:0] wbyte, head;
  logic              push_req, pop_req, push_ok, pop_ok;

  assign buffer_empty = (buffer_occupancy == '0);
  assign buffer_full  = (buffer_occupancy == BUFFER_OCC_W'(DEPTH));

  // The RX engine wins a same-cycle store; the slave's byte is dropped.
  assign wbyte    = store_rx_packet_data ? rx_packet_data : tx_data;
  assign push_req = store_rx_packet_data | store_tx_data;
  assign pop_req  = get_rx_data | get_tx_packet_data;

  // A pop frees the head slot, so a push into a full buffer is legal
  // in the same cycle; on empty only the push goes through.
  assign pop_ok  = pop_req & ~clear & ~buffer_empty;
  assign push_ok = push_req & ~clear & (~buffer_full | pop_ok);

  usb_buffer_mem #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .we   (push_ok),
    .waddr(wptr),
    .wdata(wbyte),
    .raddr(rptr),
    .rdata(head)
  );

  assign rx_data        = buffer_empty ? '0 : head;
  assign tx_packet_data = buffer_empty ? '0 : head;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr             <= '0;
      rptr             <= '0;
      buffer_occupancy <= '0;
    end else if (clear) begin
      wptr             <= '0;
      rptr             <= '0;
      buffer_occupancy <= '0;
    end else begin
      if (push_ok) wptr <= wptr + ADDR_W'(1);
      if (pop_ok)  rptr <= rptr + ADDR_W'(1);
      if (push_ok && !pop_ok)
        buffer_occupancy <= buffer_occupancy + BUFFER_OCC_W'(1);
      else if (pop_ok && !push_ok)
        buffer_occupancy <= buffer_occupancy - BUFFER_OCC_W'(1);
    end
  end

`ifdef USB_BUFFER_ERR_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      buffer_overflow  <= 1'b0;
      buffer_underflow <= 1'b0;
      buffer_collision <= 1'b0;
    end else if (clear) begin
      buffer_overflow  <= 1'b0;
      buffer_underflow <= 1'b0;
      buffer_collision <= 1'b0;
    end else begin
      if (push_req && !push_ok)                     buffer_overflow  <= 1'b1;
      if (pop_req && buffer_empty)                  buffer_underflow <= 1'b1;
      if (store_rx_packet_data && store_tx_data)    buffer_collision <= 1'b1;
    end
  end
`endif

endmodule
